// File: rtl/ifetch_pkg.sv
// Shared sizes and the fetch buffer entry type for the instruction fetch stage.
package ifetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam int IMEM_AW     = 11;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between the ROM port and decode; flush wins over push/pop.
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(FETCH_DEPTH);

  fetch_entry_t [FETCH_DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(FETCH_DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues ROM reads, tags each with its PC, buffers results for decode.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_re,
  input  logic [31:0]        imem_data,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               misalign
);
  logic [31:0]  pc;
  logic         issue, xfer, push, full, empty, inflight_vld;
  logic [1:0]   occ;
  logic [2:0]   pending;
  fetch_entry_t push_data, head;

  assign xfer    = out_valid & out_ready;
  assign occ     = {full, ~full & ~empty};
  // Slots already claimed after this cycle's transfer; a new request needs one free.
  assign pending = {1'b0, occ} + {2'b0, inflight_vld} - {2'b0, xfer};
  assign issue   = ~reset & ~redirect & (pending < 3'd2);

  assign imem_re   = issue;
  assign imem_addr = pc[IMEM_AW+1:2];

  generate
    if (MEM_LATENCY == 0) begin : g_comb
      assign inflight_vld = 1'b0;
      assign push         = issue;
      assign push_data    = '{pc: pc, instr: imem_data};
    end else begin : g_sync
      logic        vld_q;
      logic [31:0] pc_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          pc_q  <= '0;
        end else begin
          vld_q <= issue;
          if (issue) pc_q <= pc;
        end
      end
      assign inflight_vld = vld_q;
      // A response landing in a redirect cycle belongs to the old stream.
      assign push         = vld_q & ~redirect;
      assign push_data    = '{pc: pc_q, instr: imem_data};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect & (|redirect_pc[1:0]);
      if (redirect)   pc <= {redirect_pc[31:2], 2'b00};
      else if (issue) pc <= pc + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_data),
    .pop   (xfer),
    .flush (redirect),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
endmodule

// File: tb/tb_ifetch.sv
// Directed bench: a synchronous-ROM and a combinational-ROM fetch unit run the same stimulus.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        reset, redirect, out_ready;
  logic [31:0] redirect_pc;

  logic [10:0] addr1, addr0;
  logic        re1, re0, vld1, vld0, mis1, mis0;
  logic [31:0] data1, data0, instr1, instr0, pc1, pc0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .imem_addr(addr1), .imem_re(re1), .imem_data(data1),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(vld1), .out_ready(out_ready),
    .out_instr(instr1), .out_pc(pc1), .misalign(mis1));

  ifetch #(.RESET_PC(32'h0), .MEM_LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .imem_addr(addr0), .imem_re(re0), .imem_data(data0),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(vld0), .out_ready(out_ready),
    .out_instr(instr0), .out_pc(pc0), .misalign(mis0));

  // ROM word k holds 0x1000_0000 + k
  always_ff @(posedge clk) if (re1) data1 <= 32'h1000_0000 + {21'd0, addr1};
  assign data0 = 32'h1000_0000 + {21'd0, addr0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_out1(input string tag, input logic [31:0] p);
    chk({tag, ".v1"}, {31'd0, vld1}, 32'd1);
    chk({tag, ".pc1"}, pc1, p);
    chk({tag, ".in1"}, instr1, 32'h1000_0000 + {21'd0, p[12:2]});
  endtask

  task automatic chk_out0(input string tag, input logic [31:0] p);
    chk({tag, ".v0"}, {31'd0, vld0}, 32'd1);
    chk({tag, ".pc0"}, pc0, p);
    chk({tag, ".in0"}, instr0, 32'h1000_0000 + {21'd0, p[12:2]});
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.v1", {31'd0, vld1}, 0);   chk("rst.v0", {31'd0, vld0}, 0);
    chk("rst.pc1", pc1, 0);            chk("rst.in1", instr1, 0);
    chk("rst.pc0", pc0, 0);            chk("rst.in0", instr0, 0);
    chk("rst.re1", {31'd0, re1}, 0);   chk("rst.re0", {31'd0, re0}, 0);
    chk("rst.mis1", {31'd0, mis1}, 0); chk("rst.mis0", {31'd0, mis0}, 0);

    reset = 1'b0;
    #1;
    chk("first.re1", {31'd0, re1}, 1);
    chk("first.addr1", {21'd0, addr1}, 0);
    @(negedge clk);
    chk("c1.v1", {31'd0, vld1}, 0);
    chk_out0("c1", 32'h0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk_out1("stream", 32'(4 * (k - 2)));
      chk_out0("stream", 32'(4 * (k - 1)));
    end

    // stall: heads freeze, requests stop once both buffers are full
    out_ready = 1'b0;
    for (int j = 6; j <= 10; j++) begin
      @(negedge clk);
      chk_out1("stall", 32'd12);
      chk_out0("stall", 32'd16);
      chk("stall.re1", {31'd0, re1}, 0);
      chk("stall.re0", {31'd0, re0}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_out1("rel1", 32'd16); chk_out0("rel1", 32'd20);
    @(negedge clk);
    chk_out1("rel2", 32'd20); chk_out0("rel2", 32'd24);

    // redirect with old-stream data buffered and in flight
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir.re1", {31'd0, re1}, 0);
    chk("redir.re0", {31'd0, re0}, 0);
    @(negedge clk);
    redirect = 1'b0;
    chk("redir.v1", {31'd0, vld1}, 0);
    chk("redir.v0", {31'd0, vld0}, 0);
    chk("redir.addr1", {21'd0, addr1}, 32'd16);
    @(negedge clk);
    chk("redir+1.v1", {31'd0, vld1}, 0);
    chk_out0("redir+1", 32'h40);
    @(negedge clk);
    chk_out1("redir+2", 32'h40);
    chk_out0("redir+2", 32'h44);

    do_redirect(32'h46);
    chk("mis.p1", {31'd0, mis1}, 1); chk("mis.p0", {31'd0, mis0}, 1);
    @(negedge clk);
    chk("mis.e1", {31'd0, mis1}, 0); chk("mis.e0", {31'd0, mis0}, 0);
    chk_out0("mis", 32'h44);
    @(negedge clk);
    chk_out1("mis", 32'h44);

    // back-to-back redirects: only the second target survives
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    chk("b2b.v1", {31'd0, vld1}, 0); chk("b2b.v0", {31'd0, vld0}, 0);
    @(negedge clk);
    chk_out0("b2b", 32'h200);
    @(negedge clk);
    chk_out1("b2b", 32'h200);
    chk_out0("b2b+", 32'h204);

    // PC and ROM word address wrap
    do_redirect(32'hFFFF_FFFC);
    chk("wrap.addr0", {21'd0, addr0}, 32'h7FF);
    @(negedge clk);
    chk_out0("wrap", 32'hFFFF_FFFC);
    chk("wrap.addr0b", {21'd0, addr0}, 0);
    @(negedge clk);
    chk_out0("wrap+", 32'h0);
    chk_out1("wrap", 32'hFFFF_FFFC);
    @(negedge clk);
    chk_out1("wrap+", 32'h0);

    // asynchronous reset mid-stream
    #2 reset = 1'b1;
    #1;
    chk("arst.v1", {31'd0, vld1}, 0); chk("arst.v0", {31'd0, vld0}, 0);
    chk("arst.pc1", pc1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst+1.v1", {31'd0, vld1}, 0);
    chk_out0("arst+1", 32'h0);
    @(negedge clk);
    chk_out1("arst+2", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
